// File: rtl/sensor_input_conditioner.sv
// Sensor front end: two-flop synchronisers, per-bit debounce, water-level
// pattern validation with a persistent fault, and the display water code.
module sensor_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned FAULT_CYCLES    = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] raw_sensors,
    output logic [5:0] stable_sensors,
    output logic [1:0] encoded_water,
    output logic       conflicting_values,
    output logic       sensors_changed
);

    localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] FAULT_LAST = 8'(FAULT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_VALID,
        ST_SUSPECT,
        ST_FAULT
    } state_t;

    logic [5:0] r_sync1;
    logic [5:0] r_sync2;
    logic [5:0] r_stable;
    logic [7:0] r_db_cnt [6];

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_fault_cnt;
    logic [7:0] w_fault_cnt_next;

    logic [2:0] w_water;
    logic       w_pattern_valid;
    logic [1:0] w_code;

    logic [1:0] r_encoded;
    logic       r_conflict;
    logic [5:0] r_prev_stable;
    logic       r_prev_conflict;
    logic       r_changed;

    // Synchronise, then let each bit's stable value follow only after a full
    // run of disagreeing samples; one agreeing sample restarts the run.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            for (int unsigned i = 0; i < 6; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= raw_sensors;
            r_sync2 <= r_sync1;
            for (int unsigned i = 0; i < 6; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DEB_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign w_water         = r_stable[2:0];
    assign w_pattern_valid = (w_water == 3'b000) || (w_water == 3'b001) ||
                             (w_water == 3'b011) || (w_water == 3'b111);

    always_comb begin
        w_code = 2'b00;
        case (w_water)
            3'b001:  w_code = 2'b01;
            3'b011:  w_code = 2'b10;
            3'b111:  w_code = 2'b11;
            default: w_code = 2'b00;
        endcase
    end

    always_comb begin
        w_state_next     = r_state;
        w_fault_cnt_next = '0;
        case (r_state)
            ST_VALID: begin
                if (!w_pattern_valid) w_state_next = ST_SUSPECT;
            end
            ST_SUSPECT: begin
                if (w_pattern_valid) begin
                    w_state_next = ST_VALID;
                end else if (r_fault_cnt == FAULT_LAST) begin
                    w_state_next = ST_FAULT;
                end else begin
                    w_fault_cnt_next = r_fault_cnt + 8'd1;
                end
            end
            ST_FAULT: begin
                if (w_pattern_valid) begin
                    if (r_fault_cnt == FAULT_LAST) begin
                        w_state_next = ST_VALID;
                    end else begin
                        w_fault_cnt_next = r_fault_cnt + 8'd1;
                    end
                end
            end
            default: w_state_next = ST_VALID;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= ST_VALID;
            r_fault_cnt     <= '0;
            r_encoded       <= '0;
            r_conflict      <= 1'b0;
            r_prev_stable   <= '0;
            r_prev_conflict <= 1'b0;
            r_changed       <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_fault_cnt     <= w_fault_cnt_next;
            if (r_state == ST_VALID && w_pattern_valid) r_encoded <= w_code;
            // Fault flag is taken from the next state so it rises with FAULT entry.
            r_conflict      <= (w_state_next == ST_FAULT);
            r_prev_stable   <= r_stable;
            r_prev_conflict <= r_conflict;
            r_changed       <= (r_stable != r_prev_stable) || (r_conflict != r_prev_conflict);
        end
    end

    assign stable_sensors     = r_stable;
    assign encoded_water      = r_encoded;
    assign conflicting_values = r_conflict;
    assign sensors_changed    = r_changed;

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Self-checking bench for sensor_input_conditioner: scenario tasks compared
// against a sample-history reference model of the conditioning rules.
module tb_sensor_input_conditioner;

    localparam int DEB = 16;
    localparam int FLT = 8;

    logic       clock;
    logic       reset;
    logic [5:0] raw_sensors;
    logic [5:0] stable_sensors;
    logic [1:0] encoded_water;
    logic       conflicting_values;
    logic       sensors_changed;

    int n_checks = 0;
    int n_fail   = 0;

    sensor_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .FAULT_CYCLES   (FLT)
    ) u_dut (
        .clock             (clock),
        .reset             (reset),
        .raw_sensors       (raw_sensors),
        .stable_sensors    (stable_sensors),
        .encoded_water     (encoded_water),
        .conflicting_values(conflicting_values),
        .sensors_changed   (sensors_changed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: a bit's stable value flips once the last DEB
    // synchroniser outputs all disagree with it; the fault rises after FLT+1
    // consecutive invalid evaluations and clears after FLT valid ones; the
    // water code is the number of wet sensors of a valid pattern.
    bit [5:0] m_stable;
    bit [1:0] m_enc;
    bit       m_fault;
    bit       m_changed;
    bit       m_pend;
    bit       m_in_valid;
    int       m_inv_run;
    int       m_val_run;
    bit [5:0] m_hist[$];

    always @(posedge clock) begin : model_b
        bit [5:0] ns;
        bit       v;
        bit       nf;
        bit       all_diff;
        if (reset) begin
            m_stable = '0; m_enc = '0; m_fault = 0; m_changed = 0; m_pend = 0;
            m_in_valid = 1; m_inv_run = 0; m_val_run = 0;
            m_hist.delete();
            for (int k = 0; k < DEB + 1; k++) m_hist.push_back(6'b0);
        end else begin
            ns = m_stable;
            for (int b = 0; b < 6; b++) begin
                all_diff = 1;
                for (int k = 1; k <= DEB; k++)
                    if (m_hist[k][b] == m_stable[b]) all_diff = 0;
                if (all_diff) ns[b] = ~m_stable[b];
            end
            v  = m_stable[2:0] inside {3'b000, 3'b001, 3'b011, 3'b111};
            nf = m_fault;
            if (!m_fault) begin
                m_inv_run = v ? 0 : m_inv_run + 1;
                if (m_inv_run >= FLT + 1) begin nf = 1; m_inv_run = 0; m_val_run = 0; end
            end else begin
                m_val_run = v ? m_val_run + 1 : 0;
                if (m_val_run >= FLT) begin nf = 0; m_inv_run = 0; m_val_run = 0; end
            end
            if (m_in_valid && v) m_enc = 2'($countones(m_stable[2:0]));
            m_in_valid = !nf && v;
            m_changed  = m_pend;
            m_pend     = (ns != m_stable) || (nf != m_fault);
            m_stable   = ns;
            m_fault    = nf;
            m_hist.push_front(raw_sensors);
            void'(m_hist.pop_back());
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        raw_sensors = '0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({stable_sensors, encoded_water, conflicting_values, sensors_changed} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 000", {stable_sensors, encoded_water, conflicting_values, sensors_changed});
        end
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            n_checks++;
            if ({stable_sensors, encoded_water, conflicting_values, sensors_changed} !== 11'b0) begin
                n_fail++;
                $display("FAIL idle_zero cycle %0d: got %h expected 000", c, {stable_sensors, encoded_water, conflicting_values, sensors_changed});
            end
        end
    endtask

    task automatic test_debounce_step();
        int edges  = 0;
        int pulses = 0;
        raw_sensors = 6'b000001;
        while (stable_sensors[0] !== 1'b1 && edges < 40) begin
            @(negedge clock);
            edges++;
            pulses += int'(sensors_changed);
            n_checks++;
            if ({stable_sensors, encoded_water, conflicting_values, sensors_changed} !== {m_stable, m_enc, m_fault, m_changed}) begin
                n_fail++;
                $display("FAIL step_model: got %h expected %h", {stable_sensors, encoded_water, conflicting_values, sensors_changed}, {m_stable, m_enc, m_fault, m_changed});
            end
        end
        n_checks++;
        if (edges != DEB + 2) begin
            n_fail++;
            $display("FAIL step_latency: got %0d edges expected %0d", edges, DEB + 2);
        end
        @(negedge clock);
        pulses += int'(sensors_changed);
        n_checks++;
        if (encoded_water !== 2'b01 || sensors_changed !== 1'b1) begin
            n_fail++;
            $display("FAIL step_encode: got enc=%b chg=%b expected enc=01 chg=1", encoded_water, sensors_changed);
        end
        repeat (10) begin
            @(negedge clock);
            pulses += int'(sensors_changed);
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL step_pulses: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_glitch();
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 16; c++) begin
                raw_sensors[3] = (c < 15);
                @(negedge clock);
                n_checks++;
                if (stable_sensors[3] !== 1'b0 ||
                    {stable_sensors, encoded_water, conflicting_values, sensors_changed} !== {m_stable, m_enc, m_fault, m_changed}) begin
                    n_fail++;
                    $display("FAIL glitch_reject: got %h expected %h", {stable_sensors, encoded_water, conflicting_values, sensors_changed}, {m_stable, m_enc, m_fault, m_changed});
                end
            end
        end
        raw_sensors[3] = 1'b0;
        repeat (20) @(negedge clock);
        n_checks++;
        if (stable_sensors !== 6'b000001) begin
            n_fail++;
            $display("FAIL glitch_final: got %b expected 000001", stable_sensors);
        end
    endtask

    task automatic test_fault();
        int e = 0;
        raw_sensors = 6'b000010;
        while (stable_sensors[2:0] !== 3'b010 && e < 40) begin
            @(negedge clock);
            e++;
            n_checks++;
            if ({stable_sensors, encoded_water, conflicting_values, sensors_changed} !== {m_stable, m_enc, m_fault, m_changed}) begin
                n_fail++;
                $display("FAIL fault_model_a: got %h expected %h", {stable_sensors, encoded_water, conflicting_values, sensors_changed}, {m_stable, m_enc, m_fault, m_changed});
            end
        end
        e = 0;
        while (conflicting_values !== 1'b1 && e < 30) begin
            @(negedge clock);
            e++;
            n_checks++;
            if ({stable_sensors, encoded_water, conflicting_values, sensors_changed} !== {m_stable, m_enc, m_fault, m_changed}) begin
                n_fail++;
                $display("FAIL fault_model_b: got %h expected %h", {stable_sensors, encoded_water, conflicting_values, sensors_changed}, {m_stable, m_enc, m_fault, m_changed});
            end
        end
        n_checks++;
        if (e != FLT + 1 || encoded_water !== 2'b01) begin
            n_fail++;
            $display("FAIL fault_entry: got %0d edges enc=%b expected %0d edges enc=01", e, encoded_water, FLT + 1);
        end
        raw_sensors = 6'b000011;
        e = 0;
        while (stable_sensors[2:0] !== 3'b011 && e < 40) begin
            @(negedge clock);
            e++;
            n_checks++;
            if (conflicting_values !== 1'b1 ||
                {stable_sensors, encoded_water, conflicting_values, sensors_changed} !== {m_stable, m_enc, m_fault, m_changed}) begin
                n_fail++;
                $display("FAIL fault_hold: got %h expected %h", {stable_sensors, encoded_water, conflicting_values, sensors_changed}, {m_stable, m_enc, m_fault, m_changed});
            end
        end
        e = 0;
        while (conflicting_values !== 1'b0 && e < 30) begin
            @(negedge clock);
            e++;
        end
        n_checks++;
        if (e != FLT) begin
            n_fail++;
            $display("FAIL fault_recover: got %0d edges expected %0d", e, FLT);
        end
        repeat (2) @(negedge clock);
        n_checks++;
        if (encoded_water !== 2'b10 || conflicting_values !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_recover_enc: got enc=%b conf=%b expected enc=10 conf=0", encoded_water, conflicting_values);
        end
    endtask

    task automatic test_short_invalid();
        int inv = 0;
        raw_sensors = 6'b000001;
        repeat (25) @(negedge clock);
        raw_sensors[2] = 1'b1;
        repeat (5) @(negedge clock);
        raw_sensors[1] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (stable_sensors[2:0] === 3'b101) inv++;
            n_checks++;
            if (conflicting_values !== 1'b0 ||
                {stable_sensors, encoded_water, conflicting_values, sensors_changed} !== {m_stable, m_enc, m_fault, m_changed}) begin
                n_fail++;
                $display("FAIL short_invalid: got %h expected %h", {stable_sensors, encoded_water, conflicting_values, sensors_changed}, {m_stable, m_enc, m_fault, m_changed});
            end
        end
        n_checks++;
        if (inv != 5 || encoded_water !== 2'b11) begin
            n_fail++;
            $display("FAIL short_invalid_end: got inv=%0d enc=%b expected inv=5 enc=11", inv, encoded_water);
        end
    endtask

    task automatic test_reset_mid();
        int e = 0;
        raw_sensors = 6'b010010;
        while (conflicting_values !== 1'b1 && e < 60) begin
            @(negedge clock);
            e++;
        end
        n_checks++;
        if (conflicting_values !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_fault: got conf=%b expected 1", conflicting_values);
        end
        raw_sensors[5] = 1'b1;
        repeat (12) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_checks++;
        if ({stable_sensors, encoded_water, conflicting_values, sensors_changed} !== 11'b0) begin
            n_fail++;
            $display("FAIL rst_mid_state: got %h expected 000", {stable_sensors, encoded_water, conflicting_values, sensors_changed});
        end
        e = 0;
        while (stable_sensors === 6'b0 && e < 40) begin
            @(negedge clock);
            e++;
        end
        n_checks++;
        if (e != DEB + 2 || stable_sensors !== 6'b110010) begin
            n_fail++;
            $display("FAIL rst_mid_restart: got %0d edges stable=%b expected %0d edges stable=110010", e, stable_sensors, DEB + 2);
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            n_checks++;
            if ({stable_sensors, encoded_water, conflicting_values, sensors_changed} !== {m_stable, m_enc, m_fault, m_changed}) begin
                n_fail++;
                $display("FAIL rst_mid_model: got %h expected %h", {stable_sensors, encoded_water, conflicting_values, sensors_changed}, {m_stable, m_enc, m_fault, m_changed});
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 19) == 0) raw_sensors = 6'($urandom);
            @(negedge clock);
            n_checks++;
            if ({stable_sensors, encoded_water, conflicting_values, sensors_changed} !== {m_stable, m_enc, m_fault, m_changed}) begin
                n_fail++;
                $display("FAIL random_model cycle %0d: got %h expected %h", c, {stable_sensors, encoded_water, conflicting_values, sensors_changed}, {m_stable, m_enc, m_fault, m_changed});
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        raw_sensors = '0;
        test_reset();
        test_debounce_step();
        test_glitch();
        test_fault();
        test_short_invalid();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
